// File: rtl/fixed_pt_mult_pipe.sv
// fixed_pt_mult_pipe
//   Three-stage pipelined, multi-lane signed fixed-point multiplier with
//   valid/ready flow control, per-beat rounding and optional saturation.
//   S1 captures operands, S2 forms the exact 2W-bit product, S3 rounds,
//   rescales, range-checks and registers the result.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   input beat present
//   in_ready   block accepts the beat this cycle
//   round_en   1 = round half up, 0 = truncate (travels with the beat)
//   operand1   LANES packed two's-complement operands, lane i at [i*W +: W]
//   operand2   same packing as operand1
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   product    LANES packed results, lane i at [i*W +: W]
//   overflow   per-lane out-of-range flag
module fixed_pt_mult_pipe #(
  parameter int OPERAND_WIDTH = 24,
  parameter int DECIMAL_PLACE = 12,
  parameter int LANES         = 3,
  parameter int SATURATE      = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             round_en,
  input  logic [LANES*OPERAND_WIDTH-1:0]   operand1,
  input  logic [LANES*OPERAND_WIDTH-1:0]   operand2,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES*OPERAND_WIDTH-1:0]   product,
  output logic [LANES-1:0]                 overflow
);

  localparam int W = OPERAND_WIDTH;
  localparam int D = DECIMAL_PLACE;

  // Constants are 2W+1 bits wide so the rounding add can never overflow.
  localparam logic signed [2*W:0] C_ZERO = '0;
  localparam logic signed [2*W:0] C_HALF = {{(2*W){1'b0}}, 1'b1} << (D - 1);
  localparam logic signed [2*W:0] C_MAX  = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] C_MIN  = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  // Round/shift/range-check one lane; returns {overflow, result}.
  function automatic logic [W:0] scale_lane(input logic [2*W-1:0] full,
                                            input logic rnd);
    logic signed [2*W:0] t;
    logic signed [2*W:0] s;
    logic                ovf;
    logic [W-1:0]        res;
    t   = $signed({full[2*W-1], full}) + (rnd ? C_HALF : C_ZERO);
    s   = t >>> D;
    ovf = (s > C_MAX) || (s < C_MIN);
    if ((SATURATE != 32'd0) && ovf) begin
      res = s[2*W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      res = s[W-1:0];
    end
    return {ovf, res};
  endfunction

  logic                         r_v1;
  logic                         r_v2;
  logic                         r_v3;
  logic                         r_rnd1;
  logic                         r_rnd2;
  logic [LANES*W-1:0]           r_op1;
  logic [LANES*W-1:0]           r_op2;
  logic [LANES-1:0][2*W-1:0]    r_full;
  logic [LANES*W-1:0]           r_prod;
  logic [LANES-1:0]             r_ovf;

  logic                         w_ld1;
  logic                         w_ld2;
  logic                         w_ld3;
  logic [LANES-1:0][2*W-1:0]    w_full;
  logic [LANES-1:0][W:0]        w_res;

  // A stage may load when it is empty or its successor is loading.
  assign w_ld3 = !r_v3 || out_ready;
  assign w_ld2 = !r_v2 || w_ld3;
  assign w_ld1 = !r_v1 || w_ld2;

  // Gated by rst so the block never advertises space while held in reset.
  assign in_ready  = w_ld1 && !rst;
  assign out_valid = r_v3;
  assign product   = r_prod;
  assign overflow  = r_ovf;

  // Exact signed products: operands are sign-extended to 2W before multiplying.
  always_comb begin
    w_full = '0;
    for (int i = 0; i < LANES; i++) begin
      w_full[i] = $signed({{W{r_op1[i*W+W-1]}}, r_op1[i*W +: W]}) *
                  $signed({{W{r_op2[i*W+W-1]}}, r_op2[i*W +: W]});
    end
  end

  // Rescale every lane of the S2 product independently.
  always_comb begin
    w_res = '0;
    for (int i = 0; i < LANES; i++) begin
      w_res[i] = scale_lane(r_full[i], r_rnd2);
    end
  end

  // S1: operand and rounding-mode capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_rnd1 <= 1'b0;
      r_op1  <= '0;
      r_op2  <= '0;
    end else if (w_ld1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_rnd1 <= round_en;
        r_op1  <= operand1;
        r_op2  <= operand2;
      end
    end
  end

  // S2: full-precision product register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2   <= 1'b0;
      r_rnd2 <= 1'b0;
      r_full <= '0;
    end else if (w_ld2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_rnd2 <= r_rnd1;
        r_full <= w_full;
      end
    end
  end

  // S3: output register; holds steady while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v3   <= 1'b0;
      r_prod <= '0;
      r_ovf  <= '0;
    end else if (w_ld3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        for (int i = 0; i < LANES; i++) begin
          r_prod[i*W +: W] <= w_res[i][W-1:0];
          r_ovf[i]         <= w_res[i][W];
        end
      end
    end
  end

endmodule

// File: tb/tb_fixed_pt_mult_pipe.sv
module tb_fixed_pt_mult_pipe;

  localparam int W = 24;
  localparam int L = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           round_en = 1'b0;
  logic           out_ready = 1'b0;
  logic [L*W-1:0] operand1 = '0;
  logic [L*W-1:0] operand2 = '0;
  logic           in_ready, out_valid;
  logic [L*W-1:0] product;
  logic [L-1:0]   overflow;
  logic           in_ready_w, out_valid_w;
  logic [L*W-1:0] product_w;
  logic [L-1:0]   overflow_w;

  always #5 clk = ~clk;

  fixed_pt_mult_pipe #(.OPERAND_WIDTH(W), .DECIMAL_PLACE(12), .LANES(L), .SATURATE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .round_en(round_en),
    .operand1(operand1), .operand2(operand2), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .overflow(overflow));

  fixed_pt_mult_pipe #(.OPERAND_WIDTH(W), .DECIMAL_PLACE(12), .LANES(L), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .round_en(round_en),
    .operand1(operand1), .operand2(operand2), .out_valid(out_valid_w), .out_ready(out_ready),
    .product(product_w), .overflow(overflow_w));

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: exact product, optional +0.5 LSB, arithmetic shift, range check.
  function automatic logic [24:0] ref_lane(input logic [23:0] a, input logic [23:0] b,
                                           input logic rnd, input bit sat);
    longint fa, fb, s;
    logic [23:0] r;
    logic ov;
    fa = longint'($signed(a));
    fb = longint'($signed(b));
    s  = fa * fb;
    if (rnd) s = s + 64'sd2048;
    s  = s >>> 12;
    ov = (s > 64'sd8388607) || (s < -64'sd8388608);
    if (ov && sat) r = (s < 0) ? 24'h800000 : 24'h7FFFFF;
    else           r = s[23:0];
    return {ov, r};
  endfunction

  typedef struct packed {
    logic [L*W-1:0] p;
    logic [L-1:0]   ov;
  } exp_t;

  function automatic exp_t model(input logic [L*W-1:0] a, input logic [L*W-1:0] b, input logic rnd);
    exp_t e;
    logic [24:0] r;
    for (int i = 0; i < L; i++) begin
      r = ref_lane(a[i*W +: W], b[i*W +: W], rnd, 1'b1);
      e.p[i*W +: W] = r[23:0];
      e.ov[i] = r[24];
    end
    return e;
  endfunction

  exp_t q[$];
  bit   sb_on = 1'b0;
  int   tx_cnt = 0;
  int   rx_cnt = 0;

  // Scoreboard sampled on the falling edge, where inputs and outputs are stable.
  always @(negedge clk) begin
    if (sb_on && !rst) begin
      if (out_valid && out_ready) begin
        check_eq("sb_queue_nonempty", 72'(q.size() > 0), 72'd1);
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          check_eq("sb_product", product, e.p);
          check_eq("sb_overflow", 72'(overflow), 72'(e.ov));
        end
        rx_cnt++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(operand1, operand2, round_en));
        tx_cnt++;
      end
    end
  end

  // One beat into an empty pipe: check acceptance, latency and both result flavours.
  task automatic one_beat(input string tag, input logic [71:0] a, input logic [71:0] b,
                          input logic rnd, input logic [71:0] ep, input logic [2:0] eov,
                          input logic [71:0] epw, input logic [2:0] eovw);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    operand1  = a;
    operand2  = b;
    round_en  = rnd;
    #1;
    check_eq({tag, "_in_ready"}, 72'(in_ready), 72'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_latency"}, 72'(lat), 72'd3);
    check_eq({tag, "_product"}, product, ep);
    check_eq({tag, "_overflow"}, 72'(overflow), 72'(eov));
    check_eq({tag, "_wrap_product"}, product_w, epw);
    check_eq({tag, "_wrap_overflow"}, 72'(overflow_w), 72'(eovw));
    @(posedge clk); #1;
    check_eq({tag, "_drained"}, 72'(out_valid), 72'd0);
  endtask

  function automatic logic [23:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 24'h7FFFFF;
      1:       return 24'h800000;
      2:       return 24'($urandom_range(0, 4095));
      default: return 24'($urandom);
    endcase
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, cyc;
    logic [71:0] hold;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 72'(out_valid), 72'd0);
    check_eq("rst_product", product, 72'd0);
    check_eq("rst_overflow", 72'(overflow), 72'd0);
    check_eq("rst_in_ready", 72'(in_ready), 72'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", 72'(in_ready), 72'd1);
    @(posedge clk); #1;

    // Lanes packed {lane2, lane1, lane0}.
    one_beat("trunc", {24'h000001, 24'hFFE800, 24'h001800}, {24'h000800, 24'h002000, 24'h002000}, 1'b0,
             {24'h000000, 24'hFFD000, 24'h003000}, 3'b000, {24'h000000, 24'hFFD000, 24'h003000}, 3'b000);
    one_beat("round", {24'h000001, 24'hFFE800, 24'h001800}, {24'h000800, 24'h002000, 24'h002000}, 1'b1,
             {24'h000001, 24'hFFD000, 24'h003000}, 3'b000, {24'h000001, 24'hFFD000, 24'h003000}, 3'b000);
    one_beat("sat", {24'h001800, 24'h800000, 24'h7FFFFF}, {24'h002000, 24'h7FFFFF, 24'h7FFFFF}, 1'b0,
             {24'h003000, 24'h800000, 24'h7FFFFF}, 3'b011, {24'h003000, 24'h000800, 24'hFFF000}, 3'b011);
    one_beat("round_edge", {24'h7FFFFF, 24'h7FFFFF, 24'hFFFFFF}, {24'h001000, 24'h000001, 24'h000800}, 1'b1,
             {24'h7FFFFF, 24'h000800, 24'h000000}, 3'b000, {24'h7FFFFF, 24'h000800, 24'h000000}, 3'b000);
    one_beat("min_edge", {24'h800000, 24'hFFFFFF, 24'h800000}, {24'hFFF000, 24'h000800, 24'h001000}, 1'b0,
             {24'h7FFFFF, 24'hFFFFFF, 24'h800000}, 3'b100, {24'h800000, 24'hFFFFFF, 24'h800000}, 3'b100);

    // Backpressure: 10 beats, downstream stalled for cycles 4..9.
    sb_on = 1'b1; tx_cnt = 0; rx_cnt = 0; k = 0; cyc = 0; hold = '0;
    while ((k < 10 || q.size() > 0) && cyc < 200) begin
      out_ready = !(cyc >= 4 && cyc <= 9);
      in_valid  = (k < 10);
      round_en  = k[0];
      for (int i = 0; i < L; i++) begin
        operand1[i*W +: W] = 24'(k * 4096 + i * 2048 + 256);
        operand2[i*W +: W] = 24'(4096 + k * 1024 - i * 512);
      end
      #2;
      if (cyc == 5) hold = product;
      if (cyc == 9) begin
        check_eq("bp_in_ready_stalled", 72'(in_ready), 72'd0);
        check_eq("bp_out_valid_held", 72'(out_valid), 72'd1);
        check_eq("bp_product_stable", product, hold);
        check_eq("bp_occupancy", 72'(tx_cnt - rx_cnt), 72'd3);
      end
      if (in_valid && in_ready) k++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check_eq("bp_no_timeout", 72'(cyc < 200), 72'd1);
    check_eq("bp_rx_count", 72'(rx_cnt), 72'd10);

    // Random mixed traffic against the reference model.
    tx_cnt = 0; rx_cnt = 0; k = 0; cyc = 0;
    while ((k < 2000 || q.size() > 0) && cyc < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (k < 2000) && ($urandom_range(0, 3) != 0);
      round_en  = 1'($urandom_range(0, 1));
      for (int i = 0; i < L; i++) begin
        operand1[i*W +: W] = rnd_op();
        operand2[i*W +: W] = rnd_op();
      end
      #2;
      if (in_valid && in_ready) k++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check_eq("rand_no_timeout", 72'(cyc < 20000), 72'd1);
    check_eq("rand_rx_count", 72'(rx_cnt), 72'(tx_cnt));
    check_eq("rand_tx_count", 72'(tx_cnt), 72'd2000);

    // Reset with three beats in flight.
    sb_on = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    operand1  = {24'h7FFFFF, 24'h123456, 24'h001800};
    operand2  = {24'h7FFFFF, 24'h00ABCD, 24'h002000};
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("flush_full", 72'(out_valid), 72'd1);
    rst = 1'b1;
    #1;
    check_eq("flush_out_valid", 72'(out_valid), 72'd0);
    check_eq("flush_product", product, 72'd0);
    check_eq("flush_in_ready", 72'(in_ready), 72'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    one_beat("after_rst", {24'h000001, 24'hFFE800, 24'h001800}, {24'h000800, 24'h002000, 24'h002000}, 1'b1,
             {24'h000001, 24'hFFD000, 24'h003000}, 3'b000, {24'h000001, 24'hFFD000, 24'h003000}, 3'b000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
